// File: rtl/reg_bus_arbiter_if.sv
// Bundle of the requester-side and register-bus-side signals around the arbiter.
// master: the arbiter's view. It drives grants, completions and the register bus.
// slave: the environment's view. Requesters and the addressed register slave drive it.
interface reg_bus_arbiter_if #(
   parameter int address_width = 15,
   parameter int data_width    = 16,
   parameter int NUM_REQ       = 2
);
   // requester side, packed per requester i at [i*width +: width]
   logic [NUM_REQ-1:0]               req;
   logic [NUM_REQ-1:0]               rd_wr;
   logic [NUM_REQ*address_width-1:0] addr;
   logic [NUM_REQ*data_width-1:0]    wdata;
   logic [NUM_REQ-1:0]               gnt;
   logic [NUM_REQ-1:0]               done;
   logic [data_width-1:0]            rdata;
   logic                             err;
   // register bus side
   logic                             bus_valid;
   logic [address_width-1:0]         bus_addr;
   logic [data_width-1:0]            bus_data;
   logic                             bus_rd_wr;
   logic [data_width-1:0]            bus_rdata;
   logic                             bus_ack;

   modport master (
      input  req, rd_wr, addr, wdata, bus_rdata, bus_ack,
      output gnt, done, rdata, err, bus_valid, bus_addr, bus_data, bus_rd_wr
   );

   modport slave (
      output req, rd_wr, addr, wdata, bus_rdata, bus_ack,
      input  gnt, done, rdata, err, bus_valid, bus_addr, bus_data, bus_rd_wr
   );
endinterface

// File: rtl/reg_bus_arbiter.sv
// Round-robin arbiter sharing one register bus among NUM_REQ masters, one transaction at a time.
// Latency: grant and bus_valid one cycle after req in IDLE; done one cycle after ack or timeout (min 3 cycles/txn).
// Backpressure: requesters hold req until done; a slave that never acks is released after TIMEOUT_CYCLES with err.
// Ports: clk_i, reset_n_i (async active-low) and rb (master modport): req/rd_wr/addr/wdata in,
//   gnt/done/rdata/err out per requester; bus_valid/bus_addr/bus_data/bus_rd_wr out, bus_rdata/bus_ack in.
module reg_bus_arbiter #(
   parameter int address_width  = 15,
   parameter int data_width     = 16,
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic              clk_i,
   input  logic              reset_n_i,
   reg_bus_arbiter_if.master rb
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CW = $clog2(TIMEOUT_CYCLES);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUS  = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]               state;
   logic [IW-1:0]            rr_ptr;
   logic [CW-1:0]            tmo_cnt;
   logic [NUM_REQ-1:0]       gnt_q;
   logic [NUM_REQ-1:0]       done_q;
   logic [data_width-1:0]    rdata_q;
   logic                     err_q;
   logic                     valid_q;
   logic [address_width-1:0] addr_q;
   logic [data_width-1:0]    data_q;
   logic                     rd_wr_q;

   logic [IW-1:0]            cand;
   logic [IW-1:0]            win_idx;
   logic                     win_vld;
   logic [IW-1:0]            next_ptr;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
      int sum;
      sum = int'(base) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return sum[IW-1:0];
   endfunction

   // Walk offsets from the highest down so the candidate closest to rr_ptr
   // is the last one written and therefore wins.
   always_comb begin
      cand    = '0;
      win_idx = '0;
      win_vld = 1'b0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         cand = wrap_add(rr_ptr, k);
         if (rb.req[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
      next_ptr = (win_idx == IW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state   <= S_IDLE;
         rr_ptr  <= '0;
         tmo_cnt <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rd_wr_q <= 1'b0;
      end else begin
         done_q <= '0;
         case (state)
            S_IDLE: begin
               if (win_vld) begin
                  gnt_q   <= NUM_REQ'(1) << win_idx;
                  addr_q  <= rb.addr[win_idx*address_width +: address_width];
                  data_q  <= rb.wdata[win_idx*data_width +: data_width];
                  rd_wr_q <= rb.rd_wr[win_idx];
                  valid_q <= 1'b1;
                  tmo_cnt <= '0;
                  rr_ptr  <= next_ptr;
                  state   <= S_BUS;
               end
            end
            S_BUS: begin
               // ack is checked first so an ack on the last timeout cycle still succeeds
               if (rb.bus_ack) begin
                  rdata_q <= rd_wr_q ? '0 : rb.bus_rdata;
                  err_q   <= 1'b0;
                  valid_q <= 1'b0;
                  done_q  <= gnt_q;
                  state   <= S_RESP;
               end else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  rdata_q <= '0;
                  err_q   <= 1'b1;
                  valid_q <= 1'b0;
                  done_q  <= gnt_q;
                  state   <= S_RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_RESP: begin
               gnt_q <= '0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign rb.gnt       = gnt_q;
   assign rb.done      = done_q;
   assign rb.rdata     = rdata_q;
   assign rb.err       = err_q;
   assign rb.bus_valid = valid_q;
   assign rb.bus_addr  = addr_q;
   assign rb.bus_data  = data_q;
   assign rb.bus_rd_wr = rd_wr_q;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// Testbench for reg_bus_arbiter: scripted requesters, a responding register slave
// and a completion scoreboard checked on every done pulse.
// Ends with one summary line of check and error counts.
module tb_reg_bus_arbiter;
   localparam int AW  = 15;
   localparam int DW  = 16;
   localparam int NR  = 2;
   localparam int TMO = 64;

   typedef struct packed {
      logic [NR-1:0] done;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   logic clk_i;
   logic reset_n_i;

   reg_bus_arbiter_if #(.address_width(AW), .data_width(DW), .NUM_REQ(NR)) rb ();

   reg_bus_arbiter #(
      .address_width(AW), .data_width(DW), .NUM_REQ(NR), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk_i    (clk_i),
      .reset_n_i(reset_n_i),
      .rb       (rb)
   );

   int checks = 0;
   int errors = 0;
   exp_t sb[$];
   logic [NR-1:0] glog[$];

   // register slave model
   int ack_delay = -1;
   int bus_cnt = 0;
   logic slv_fixed = 1'b1;
   logic [DW-1:0] slv_data = '0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   initial begin
      #2000000;
      $display("FAIL watchdog got=still_running exp=finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push_exp(input logic [NR-1:0] d, input logic [DW-1:0] r, input logic e);
      exp_t x;
      x.done  = d;
      x.rdata = r;
      x.err   = e;
      sb.push_back(x);
   endtask

   // Advances at least one negedge; n = negedges until done, v = of those with bus_valid.
   task automatic wait_done(input int budget, output int n, output int v);
      n = 0;
      v = 0;
      do begin
         @(negedge clk_i);
         n++;
         if (rb.bus_valid) v++;
      end while (!(|rb.done) && n < budget);
      if (!(|rb.done)) chk("wait_done", 32'd0, 32'd1);
   endtask

   // slave: acks exactly once, ack_delay negedges into the bus phase
   always @(negedge clk_i) begin
      if (rb.bus_valid) bus_cnt++;
      else bus_cnt = 0;
      if (rb.bus_valid && bus_cnt == ack_delay) begin
         rb.bus_ack   = 1'b1;
         rb.bus_rdata = slv_fixed ? slv_data : ({1'b0, rb.bus_addr} ^ 16'h5A5A);
      end else begin
         rb.bus_ack   = 1'b0;
         rb.bus_rdata = 16'hDEAD;
      end
   end

   // completion monitor and grant log
   logic [NR-1:0] prev_done = '0;
   logic prev_valid = 1'b0;
   always @(negedge clk_i) begin
      exp_t e;
      if (|rb.done) begin
         chk("done_one_cycle", 32'(prev_done), 32'd0);
         chk("valid_in_resp", 32'(rb.bus_valid), 32'd0);
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'(rb.done), 32'd0);
         end else begin
            e = sb.pop_front();
            chk("done_owner", 32'(rb.done), 32'(e.done));
            chk("rdata", 32'(rb.rdata), 32'(e.rdata));
            chk("err", 32'(rb.err), 32'(e.err));
         end
      end
      if (rb.bus_valid && !prev_valid) glog.push_back(rb.gnt);
      prev_done  = rb.done;
      prev_valid = rb.bus_valid;
   end

   initial begin
      int n;
      int v;
      logic [NR-1:0] order [4];
      order = '{2'b01, 2'b10, 2'b01, 2'b10};

      reset_n_i = 1'b0;
      rb.req   = '0;
      rb.rd_wr = '0;
      rb.addr  = '0;
      rb.wdata = '0;
      repeat (3) @(negedge clk_i);
      chk("rst_gnt", 32'(rb.gnt), 32'd0);
      chk("rst_done", 32'(rb.done), 32'd0);
      chk("rst_valid", 32'(rb.bus_valid), 32'd0);
      chk("rst_rdata_err", 32'({rb.rdata, rb.err}), 32'd0);
      chk("rst_bus", 32'({rb.bus_addr, rb.bus_data, rb.bus_rd_wr}), 32'd0);
      reset_n_i = 1'b1;
      @(negedge clk_i);

      // single read from requester 0
      ack_delay = 3;
      slv_fixed = 1'b1;
      slv_data  = 16'hBEEF;
      rb.addr[0 +: AW] = 15'h0010;
      rb.rd_wr = 2'b00;
      rb.req   = 2'b01;
      push_exp(2'b01, 16'hBEEF, 1'b0);
      wait_done(20, n, v);
      chk("t1_latency", 32'(n), 32'd4);
      chk("t1_valid_cycles", 32'(v), 32'd3);
      rb.req = 2'b00;
      @(negedge clk_i);
      chk("t1_done_clear", 32'(rb.done), 32'd0);
      chk("t1_gnt_clear", 32'(rb.gnt), 32'd0);
      chk("t1_rdata_hold", 32'(rb.rdata), 32'hBEEF);

      // write from requester 1, req dropped mid-transaction
      ack_delay = 4;
      slv_data  = 16'hFFFF;
      rb.addr[AW +: AW]  = 15'h7FFF;
      rb.wdata[DW +: DW] = 16'h1234;
      rb.rd_wr = 2'b10;
      rb.req   = 2'b10;
      push_exp(2'b10, 16'h0000, 1'b0);
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         chk("t2_valid", 32'(rb.bus_valid), 32'd1);
         chk("t2_addr", 32'(rb.bus_addr), 32'h7FFF);
         chk("t2_data", 32'(rb.bus_data), 32'h1234);
         chk("t2_rd_wr", 32'(rb.bus_rd_wr), 32'd1);
         if (c == 1) rb.req = 2'b00;
      end
      wait_done(10, n, v);
      chk("t2_done_after_ack", 32'(n), 32'd1);
      @(negedge clk_i);

      // both requesting: strict alternation, read data routed per address
      slv_fixed = 1'b0;
      ack_delay = 1;
      rb.addr[0 +: AW]  = 15'h0100;
      rb.addr[AW +: AW] = 15'h0200;
      rb.rd_wr = 2'b00;
      glog.delete();
      rb.req = 2'b11;
      for (int i = 0; i < 4; i++)
         push_exp(order[i], (order[i] == 2'b01) ? 16'h5B5A : 16'h585A, 1'b0);
      for (int i = 0; i < 4; i++) begin
         wait_done(10, n, v);
         if (i == 3) rb.req = 2'b00;
      end
      @(negedge clk_i);
      chk("t3_grants", 32'(glog.size()), 32'd4);
      for (int i = 0; i < glog.size() && i < 4; i++) begin
         chk("t3_order", 32'(glog[i]), 32'(order[i]));
         if (i > 0) chk("t3_alternate", 32'(glog[i] != glog[i-1]), 32'd1);
      end

      // no ack: timeout after TMO bus cycles
      slv_fixed = 1'b1;
      slv_data  = 16'h7777;
      ack_delay = -1;
      rb.addr[0 +: AW] = 15'h0ABC;
      rb.req = 2'b01;
      push_exp(2'b01, 16'h0000, 1'b1);
      wait_done(TMO + 20, n, v);
      chk("t4_bus_cycles", 32'(v), 32'(TMO));
      chk("t4_latency", 32'(n), 32'(TMO + 1));
      rb.req = 2'b00;
      @(negedge clk_i);

      // following transaction is normal
      ack_delay = 2;
      slv_data  = 16'h0F0F;
      rb.addr[AW +: AW] = 15'h0003;
      rb.req = 2'b10;
      push_exp(2'b10, 16'h0F0F, 1'b0);
      wait_done(20, n, v);
      chk("t4b_valid_cycles", 32'(v), 32'd2);
      rb.req = 2'b00;
      @(negedge clk_i);

      // ack on the final timeout cycle wins
      ack_delay = TMO;
      slv_data  = 16'hCAFE;
      rb.addr[0 +: AW] = 15'h0042;
      rb.req = 2'b01;
      push_exp(2'b01, 16'hCAFE, 1'b0);
      wait_done(TMO + 20, n, v);
      chk("t5_bus_cycles", 32'(v), 32'(TMO));
      rb.req = 2'b00;
      @(negedge clk_i);

      // reset in the middle of a bus write
      ack_delay = -1;
      rb.addr[0 +: AW]  = 15'h1357;
      rb.wdata[0 +: DW] = 16'h2468;
      rb.rd_wr = 2'b01;
      rb.req   = 2'b01;
      repeat (3) @(negedge clk_i);
      chk("t6_pre_valid", 32'(rb.bus_valid), 32'd1);
      reset_n_i = 1'b0;
      rb.req    = 2'b00;
      #1;
      chk("t6_gnt", 32'(rb.gnt), 32'd0);
      chk("t6_valid", 32'(rb.bus_valid), 32'd0);
      chk("t6_rdata_err", 32'({rb.rdata, rb.err}), 32'd0);
      chk("t6_bus", 32'({rb.bus_addr, rb.bus_data, rb.bus_rd_wr}), 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      rb.rd_wr  = 2'b00;
      rb.addr[AW +: AW] = 15'h0022;
      slv_data  = 16'h4444;
      ack_delay = 1;
      rb.req = 2'b10;
      push_exp(2'b10, 16'h4444, 1'b0);
      wait_done(20, n, v);
      chk("t6_latency", 32'(n), 32'd2);
      rb.req = 2'b00;
      repeat (2) @(negedge clk_i);

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
